mem_ctrl: RTL and testbench

- Cache-side initiator that drives block transfers into the byte-array main memory, i.e. the memory's addr/rd_en/wr_en/wr_data/rd_data port.
- Accepts one miss-service request at a time from the cache controller: writeback, fill, or writeback-then-fill.
- Sequences the memory enables over a fixed access latency and returns the filled block with a one-cycle response pulse.
- Keeps saturating fill and writeback counters for performance statistics.

---
 rtl/macros.sv | 9 +
 rtl/mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/macros.sv
// Global address and block geometry shared by the memory-side blocks.
// 64-byte blocks over a 16-bit physical address space.
`ifndef MACROS_SV
`define MACROS_SV
`define PA_WIDTH 16
`define BLK_WIDTH 512
`define WRD_WIDTH 32
`define BYTE 8
`endif

// File: rtl/mem_ctrl.sv
// Miss-service initiator: sequences block writebacks and fills onto the
// main-memory port with a fixed access latency and saturating statistics.
`ifndef PA_WIDTH
`define PA_WIDTH 16
`endif
`ifndef BLK_WIDTH
`define BLK_WIDTH 512
`endif
`ifndef BYTE
`define BYTE 8
`endif

module mem_ctrl #(
    parameter int LATENCY   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wb,
    input  logic                  req_fill,
    input  logic [`PA_WIDTH-1:0]  req_wb_addr,
    input  logic [`PA_WIDTH-1:0]  req_fill_addr,
    input  logic [`BLK_WIDTH-1:0] req_wb_data,
    output logic                  resp_valid,
    output logic [`BLK_WIDTH-1:0] resp_data,
    output logic                  busy,
    output logic [`PA_WIDTH-1:0]  mm_addr,
    output logic                  mm_rd_en,
    output logic                  mm_wr_en,
    output logic [`BLK_WIDTH-1:0] mm_wr_data,
    input  logic [`BLK_WIDTH-1:0] mm_rd_data,
    output logic [CNT_WIDTH-1:0]  fill_cnt,
    output logic [CNT_WIDTH-1:0]  wb_cnt
);

    localparam int OFF_BITS = $clog2(`BLK_WIDTH / `BYTE);
    localparam int CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);
    localparam logic [`PA_WIDTH-1:0] ALIGN = {{(`PA_WIDTH-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   fill_q;
    logic [`PA_WIDTH-1:0]   fill_addr_q;
    logic [`PA_WIDTH-1:0]   mm_addr_q;
    logic                   mm_rd_en_q;
    logic                   mm_wr_en_q;
    logic [`BLK_WIDTH-1:0]  mm_wr_data_q;
    logic                   resp_valid_q;
    logic [`BLK_WIDTH-1:0]  resp_data_q;
    logic [CNT_WIDTH-1:0]   fill_cnt_q;
    logic [CNT_WIDTH-1:0]   wb_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fill_q       <= 1'b0;
            fill_addr_q  <= '0;
            mm_addr_q    <= '0;
            mm_rd_en_q   <= 1'b0;
            mm_wr_en_q   <= 1'b0;
            mm_wr_data_q <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            fill_cnt_q   <= '0;
            wb_cnt_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid && (req_wb || req_fill)) begin
                        fill_q      <= req_fill;
                        fill_addr_q <= req_fill_addr & ALIGN;
                        cnt_q       <= LAT_M1;
                        if (req_wb) begin
                            state_q      <= WB;
                            mm_wr_en_q   <= 1'b1;
                            mm_addr_q    <= req_wb_addr & ALIGN;
                            mm_wr_data_q <= req_wb_data;
                        end else begin
                            state_q    <= RD;
                            mm_rd_en_q <= 1'b1;
                            mm_addr_q  <= req_fill_addr & ALIGN;
                        end
                    end
                end
                WB: begin
                    if (cnt_q == '0) begin
                        mm_wr_en_q <= 1'b0;
                        if (!(&wb_cnt_q)) wb_cnt_q <= wb_cnt_q + 1'b1;
                        // Chain straight into the fill with no idle cycle.
                        if (fill_q) begin
                            state_q    <= RD;
                            mm_rd_en_q <= 1'b1;
                            mm_addr_q  <= fill_addr_q;
                            cnt_q      <= LAT_M1;
                        end else begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RD: begin
                    if (cnt_q == '0) begin
                        mm_rd_en_q   <= 1'b0;
                        resp_data_q  <= mm_rd_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                        if (!(&fill_cnt_q)) fill_cnt_q <= fill_cnt_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mm_addr    = mm_addr_q;
    assign mm_rd_en   = mm_rd_en_q;
    assign mm_wr_en   = mm_wr_en_q;
    assign mm_wr_data = mm_wr_data_q;
    assign fill_cnt   = fill_cnt_q;
    assign wb_cnt     = wb_cnt_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte-array memory model behind one
// LATENCY=4 instance and a LATENCY=1 narrow-counter instance.
`ifndef PA_WIDTH
`define PA_WIDTH 16
`endif
`ifndef BLK_WIDTH
`define BLK_WIDTH 512
`endif

module tb_mem_ctrl;

    localparam int PA = `PA_WIDTH;
    localparam int BW = `BLK_WIDTH;
    localparam int NB = BW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Instance 0: LATENCY=4, 16-bit counters, backed by byte memory
    logic          rst0, rv0, rwb0, rfill0;
    logic [PA-1:0] rwa0, rfa0;
    logic [BW-1:0] rwd0;
    logic          ready0, resp0, busy0, rd0, wr0;
    logic [BW-1:0] rdata0, wdata0, mrd0;
    logic [PA-1:0] addr0;
    logic [15:0]   fcnt0, wcnt0;

    mem_ctrl #(.LATENCY(4), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst0), .req_valid(rv0), .req_ready(ready0),
        .req_wb(rwb0), .req_fill(rfill0), .req_wb_addr(rwa0),
        .req_fill_addr(rfa0), .req_wb_data(rwd0), .resp_valid(resp0),
        .resp_data(rdata0), .busy(busy0), .mm_addr(addr0), .mm_rd_en(rd0),
        .mm_wr_en(wr0), .mm_wr_data(wdata0), .mm_rd_data(mrd0),
        .fill_cnt(fcnt0), .wb_cnt(wcnt0)
    );

    // Instance 1: LATENCY=1, 2-bit counters to reach saturation quickly
    logic          rst1, rv1;
    logic [PA-1:0] rfa1;
    logic          ready1, resp1, busy1, rd1, wr1;
    logic [BW-1:0] rdata1, wdata1, mrd1;
    logic [PA-1:0] addr1;
    logic [1:0]    fcnt1, wcnt1;

    mem_ctrl #(.LATENCY(1), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst1), .req_valid(rv1), .req_ready(ready1),
        .req_wb(1'b0), .req_fill(1'b1), .req_wb_addr('0),
        .req_fill_addr(rfa1), .req_wb_data('0), .resp_valid(resp1),
        .resp_data(rdata1), .busy(busy1), .mm_addr(addr1), .mm_rd_en(rd1),
        .mm_wr_en(wr1), .mm_wr_data(wdata1), .mm_rd_data(mrd1),
        .fill_cnt(fcnt1), .wb_cnt(wcnt1)
    );
    assign mrd1 = {(BW/PA){addr1}};

    logic [7:0] mem [0:65535];

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 13) + 7);
    endfunction

    function automatic logic [BW-1:0] pat_blk(input int a);
        logic [BW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*8 +: 8] = pat(a + b);
        return r;
    endfunction

    initial for (int i = 0; i < 65536; i++) mem[i] = pat(i);

    always_comb begin
        mrd0 = '0;
        for (int b = 0; b < NB; b++) mrd0[b*8 +: 8] = mem[int'(addr0) + b];
    end

    always @(posedge clk)
        if (wr0)
            for (int b = 0; b < NB; b++) mem[int'(addr0) + b] <= wdata0[b*8 +: 8];

    logic mon_en = 1'b0;
    always @(negedge clk)
        if (mon_en) chk("overlap", BW'(rd0 & wr0), '0);

    logic          tr_rd [0:15];
    logic          tr_wr [0:15];
    logic          tr_rv [0:15];
    logic          tr_rdy[0:15];
    logic          tr_bsy[0:15];
    logic [PA-1:0] tr_ad [0:15];
    logic [BW-1:0] tr_wd [0:15];

    task automatic txn(input logic wb, input logic fill, input logic [PA-1:0] wa,
                       input logic [PA-1:0] fa, input logic [BW-1:0] d,
                       input int n, input logic hold);
        @(negedge clk);
        chk("ready_pre", BW'(ready0), BW'(1));
        rv0 = 1'b1; rwb0 = wb; rfill0 = fill;
        rwa0 = wa; rfa0 = fa; rwd0 = d;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tr_rd[k] = rd0; tr_wr[k] = wr0; tr_rv[k] = resp0;
            tr_rdy[k] = ready0; tr_bsy[k] = busy0;
            tr_ad[k] = addr0; tr_wd[k] = wdata0;
            if (!hold) begin
                rv0 = 1'b0; rwb0 = ~wb; rfill0 = ~fill;
                rwa0 = ~wa; rfa0 = ~fa; rwd0 = ~d;
            end
        end
    endtask

    task automatic fill1(input logic [PA-1:0] a);
        logic [PA-1:0] al;
        al = a & 16'hFFC0;
        @(negedge clk);
        rv1 = 1'b1; rfa1 = a;
        @(posedge clk);
        @(negedge clk);
        rv1 = 1'b0;
        chk("l1_k1", BW'({rd1, resp1}), BW'(2'b10));
        chk("l1_addr", BW'(addr1), BW'(al));
        @(negedge clk);
        chk("l1_k2", BW'({rd1, resp1}), BW'(2'b01));
        chk("l1_data", rdata1, {(BW/PA){al}});
        @(negedge clk);
        chk("l1_k3", BW'({rd1, resp1, busy1}), BW'(3'b000));
    endtask

    logic [BW-1:0] d_a5, d_12;
    logic [2:0]    e;
    int            seen;

    initial begin
        d_a5 = {NB{8'hA5}};
        d_12 = {(BW/16){16'h1234}};
        rst0 = 1'b0; rst1 = 1'b0;
        rv0 = 1'b0; rwb0 = 1'b0; rfill0 = 1'b0;
        rwa0 = '0; rfa0 = '0; rwd0 = '0;
        rv1 = 1'b0; rfa1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", BW'({ready0, busy0}), BW'(2'b10));
        chk("rst_en", BW'({rd0, wr0, resp0}), '0);
        chk("rst_resp", rdata0, '0);
        chk("rst_addr", BW'(addr0), '0);
        chk("rst_wdata", wdata0, '0);
        chk("rst_cnt", BW'({fcnt0, wcnt0}), '0);
        rst0 = 1'b1; rst1 = 1'b1;
        mon_en = 1'b1;

        // Fill-only 0x0047
        txn(1'b0, 1'b1, 16'h0, 16'h0047, '0, 6, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            e = {k <= 4, 1'b0, k == 5};
            chk("t1_ctl", BW'({tr_rd[k], tr_wr[k], tr_rv[k]}), BW'(e));
        end
        chk("t1_addr", BW'(tr_ad[1]), BW'(16'h0040));
        chk("t1_data", rdata0, pat_blk(16'h0040));
        chk("t1_cnt", BW'({fcnt0, wcnt0}), BW'({16'd1, 16'd0}));

        // Writeback 0x0100 then fill 0x0200
        txn(1'b1, 1'b1, 16'h0100, 16'h0200, d_a5, 10, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            e = {k >= 5 && k <= 8, k <= 4, k == 9};
            chk("t2_ctl", BW'({tr_rd[k], tr_wr[k], tr_rv[k]}), BW'(e));
        end
        chk("t2_wa", BW'(tr_ad[4]), BW'(16'h0100));
        chk("t2_wd", tr_wd[1], d_a5);
        chk("t2_fa", BW'(tr_ad[5]), BW'(16'h0200));
        chk("t2_data", rdata0, pat_blk(16'h0200));
        chk("t2_cnt", BW'({fcnt0, wcnt0}), BW'({16'd2, 16'd1}));

        txn(1'b0, 1'b1, 16'h0, 16'h0123, '0, 6, 1'b0);
        chk("t2b_data", rdata0, d_a5);
        chk("t2b_rv", BW'(tr_rv[5]), BW'(1));

        // Same address for writeback and fill
        txn(1'b1, 1'b1, 16'h0300, 16'h0310, d_12, 10, 1'b0);
        chk("t3_rv", BW'({tr_rv[8], tr_rv[9], tr_rv[10]}), BW'(3'b010));
        chk("t3_data", rdata0, d_12);
        chk("t3_cnt", BW'({fcnt0, wcnt0}), BW'({16'd4, 16'd2}));

        // Back-to-back wb-only with req_valid held high
        txn(1'b1, 1'b0, 16'h0400, 16'h0, {NB{8'h5A}}, 7, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            e = {1'b0, k <= 4 || k == 7, k == 5};
            chk("t4_ctl", BW'({tr_rd[k], tr_wr[k], tr_rv[k]}), BW'(e));
            chk("t4_rdy", BW'({tr_rdy[k], tr_bsy[k]}), (k == 6) ? BW'(2'b10) : BW'(2'b01));
        end
        rv0 = 1'b0;
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp0 && seen == 0) seen = k;
        end
        chk("t4_resp2", BW'(seen), BW'(4));
        chk("t4_data", rdata0, d_12);
        chk("t4_cnt", BW'({fcnt0, wcnt0}), BW'({16'd4, 16'd4}));

        // req_valid with no operation bits is dropped
        @(negedge clk);
        rv0 = 1'b1; rwb0 = 1'b0; rfill0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t7_idle", BW'({busy0, rd0, wr0, resp0, ready0}), BW'(5'b00001));
        end
        rv0 = 1'b0;

        // Reset during the second RD cycle
        txn(1'b0, 1'b1, 16'h0, 16'h0500, '0, 1, 1'b0);
        chk("t5_rd1", BW'(tr_rd[1]), BW'(1));
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        chk("t5_rst", BW'({rd0, wr0, resp0, busy0, ready0}), BW'(5'b00001));
        chk("t5_cnt", BW'({fcnt0, wcnt0}), '0);
        chk("t5_data", rdata0, '0);
        rst0 = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp0) seen++;
        end
        chk("t5_noresp", BW'(seen), '0);
        txn(1'b0, 1'b1, 16'h0, 16'h0047, '0, 6, 1'b0);
        chk("t5_rv", BW'(tr_rv[5]), BW'(1));
        chk("t5_after", rdata0, pat_blk(16'h0040));
        chk("t5_fcnt", BW'(fcnt0), BW'(1));
        mon_en = 1'b0;

        // LATENCY=1 fills and counter saturation
        @(negedge clk);
        chk("l1_rst", BW'({fcnt1, wcnt1, ready1}), BW'(5'b00001));
        fill1(16'h0080);
        fill1(16'h00C5);
        fill1(16'h1234);
        chk("l1_cnt3", BW'(fcnt1), BW'(2'd3));
        fill1(16'h0F00);
        chk("l1_sat", BW'(fcnt1), BW'(2'd3));
        chk("l1_wb", BW'(wcnt1), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
